// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - programmable tick generator driving the up-counter enable
// Optional pause input enabled by defining TICK_GEN_PAUSE_EN.
module tick_gen #(
  parameter int PRESCALE_W = 8,
  parameter int BURST_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
`ifdef TICK_GEN_PAUSE_EN
  input  logic                  pause,
`endif
  input  logic [PRESCALE_W-1:0] div,
  input  logic [BURST_W-1:0]    burst_len,
  output logic                  enable,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [PRESCALE_W-1:0] PRE_ONE   = PRESCALE_W'(1);
  localparam logic [BURST_W-1:0]    BURST_ONE = BURST_W'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] w_prescale_nxt;
  logic [BURST_W-1:0]    r_remaining;
  logic [BURST_W-1:0]    w_remaining_nxt;
  logic                  r_enable;
  logic                  w_enable_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  w_pause;
  logic                  w_burst_mode;

`ifdef TICK_GEN_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // remaining is loaded from burst_len and never reaches 0 while in RUN,
  // so a nonzero value identifies burst mode without a separate flag.
  assign w_burst_mode = (r_remaining != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_prescale  <= '0;
      r_remaining <= '0;
      r_enable    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prescale  <= w_prescale_nxt;
      r_remaining <= w_remaining_nxt;
      r_enable    <= w_enable_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_prescale_nxt  = r_prescale;
    w_remaining_nxt = r_remaining;
    w_enable_nxt    = 1'b0;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt     = RUN;
          w_prescale_nxt  = div;
          w_remaining_nxt = burst_len;
          w_busy_nxt      = 1'b1;
        end else if (step) begin
          w_enable_nxt = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end else if (w_pause) begin
          w_busy_nxt = 1'b1;
        end else if (r_prescale == '0) begin
          w_enable_nxt   = 1'b1;
          w_prescale_nxt = div;
          if (w_burst_mode && (r_remaining == BURST_ONE)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
          end else if (w_burst_mode) begin
            w_remaining_nxt = r_remaining - BURST_ONE;
          end
        end else begin
          w_prescale_nxt = r_prescale - PRE_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign enable = r_enable;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - self-checking bench for tick_gen
// Expected pulse times are computed arithmetically from div, burst_len and stop timing.
module tb_tick_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step = 1'b0;
`ifdef TICK_GEN_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [7:0] div = 8'd0;
  logic [7:0] burst_len = 8'd0;
  logic       enable;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  tick_gen #(.PRESCALE_W(8), .BURST_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .step      (step),
`ifdef TICK_GEN_PAUSE_EN
    .pause     (pause),
`endif
    .div       (div),
    .burst_len (burst_len),
    .enable    (enable),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) cyc();
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", enable); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    reset_n = 1'b1;
    cyc();
    div = 8'd0; burst_len = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    checks++; if (enable !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL run_before_reset got=%b%b exp=11", enable, busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL async_reset_enable got=%b exp=0", enable); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL async_reset_done got=%b exp=0", done); end
    #1 reset_n = 1'b1;
    cyc();
    cyc();
    checks++; if (enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b%b exp=00", enable, busy); end
  endtask

  task automatic run_burst(input int d, input int len);
    int period;
    int last;
    int pulses;
    logic exp_en;
    logic exp_done;
    logic exp_busy;
    period = d + 1;
    last = len * period;
    pulses = 0;
    div = 8'(d); burst_len = 8'(len); start = 1'b1;
    cyc();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || enable !== 1'b0) begin failures++; $display("FAIL burst_start d=%0d len=%0d got=%b%b exp=10", d, len, busy, enable); end
    for (int c = 1; c <= last + 2; c++) begin
      cyc();
      exp_en = ((c % period) == 0) && (c <= last);
      exp_done = (c == last);
      exp_busy = (c < last);
      if (enable) pulses++;
      checks++; if (enable !== exp_en) begin failures++; $display("FAIL burst_enable d=%0d len=%0d c=%0d got=%b exp=%b", d, len, c, enable, exp_en); end
      checks++; if (done !== exp_done) begin failures++; $display("FAIL burst_done d=%0d len=%0d c=%0d got=%b exp=%b", d, len, c, done, exp_done); end
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL burst_busy d=%0d len=%0d c=%0d got=%b exp=%b", d, len, c, busy, exp_busy); end
    end
    checks++; if (pulses != len) begin failures++; $display("FAIL burst_count d=%0d got=%0d exp=%0d", d, pulses, len); end
  endtask

  task automatic run_cont(input int d, input int stop_at, input int tail);
    int period;
    logic exp_en;
    logic exp_busy;
    period = d + 1;
    div = 8'(d); burst_len = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= stop_at + tail; c++) begin
      stop = (c == stop_at);
      cyc();
      stop = 1'b0;
      exp_en = ((c % period) == 0) && (c < stop_at);
      exp_busy = (c < stop_at);
      checks++; if (enable !== exp_en) begin failures++; $display("FAIL cont_enable d=%0d c=%0d got=%b exp=%b", d, c, enable, exp_en); end
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL cont_busy d=%0d c=%0d got=%b exp=%b", d, c, busy, exp_busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL cont_done d=%0d c=%0d got=%b exp=0", d, c, done); end
    end
  endtask

  task automatic test_burst();
    run_burst(1, 5);
    run_burst(0, 1);
    for (int i = 0; i < 6; i++) begin
      run_burst(int'($urandom_range(0, 5)), int'($urandom_range(1, 6)));
    end
  endtask

  task automatic test_continuous();
    run_cont(3, 14, 4);
    for (int i = 0; i < 4; i++) begin
      run_cont(int'($urandom_range(0, 6)), int'($urandom_range(1, 30)), 3);
    end
  endtask

  task automatic test_stop_priority();
    run_cont(2, 3, 4);
  endtask

  task automatic test_div_change();
    logic exp_en;
    div = 8'd2; burst_len = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    div = 8'd4;
    for (int c = 2; c <= 15; c++) begin
      stop = (c == 15);
      cyc();
      stop = 1'b0;
      exp_en = (c == 3) || (c == 8) || (c == 13);
      checks++; if (enable !== exp_en) begin failures++; $display("FAIL divchg_enable c=%0d got=%b exp=%b", c, enable, exp_en); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL divchg_busy got=%b exp=0", busy); end
  endtask

  task automatic test_step();
    int gap;
    for (int i = 0; i < 3; i++) begin
      gap = int'($urandom_range(1, 4));
      for (int g = 0; g < gap; g++) begin
        cyc();
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL step_gap got=%b exp=0", enable); end
      end
      step = 1'b1;
      cyc();
      step = 1'b0;
      checks++; if (enable !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL step_pulse got=%b%b exp=10", enable, busy); end
      cyc();
      checks++; if (enable !== 1'b0) begin failures++; $display("FAIL step_single got=%b exp=0", enable); end
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++; if (enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stop_idle got=%b%b exp=00", enable, busy); end
    div = 8'd3; burst_len = 8'd0; start = 1'b1; step = 1'b1;
    cyc();
    start = 1'b0; step = 1'b0;
    checks++; if (enable !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL start_step got=%b%b exp=01", enable, busy); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_step_stop got=%b exp=0", busy); end
  endtask

`ifdef TICK_GEN_PAUSE_EN
  task automatic test_pause();
    logic exp_en;
    div = 8'd3; burst_len = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      pause = (c >= 2) && (c <= 5);
      stop = (c == 14);
      cyc();
      pause = 1'b0; stop = 1'b0;
      exp_en = (c == 8) || (c == 12);
      checks++; if (enable !== exp_en) begin failures++; $display("FAIL pause_enable c=%0d got=%b exp=%b", c, enable, exp_en); end
      checks++; if (busy !== (c < 14)) begin failures++; $display("FAIL pause_busy c=%0d got=%b", c, busy); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_stop_priority();
    test_div_change();
    test_step();
`ifdef TICK_GEN_PAUSE_EN
    test_pause();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
